// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_div_pkg;

   // Default counter / half-period width in bits.
   localparam int DEF_CNT_W = 32;

   // Default half-period (inClk cycles) loaded at reset.
   localparam int unsigned DEF_HALF_DEFAULT = 100000;

   // Channel-select width: at least one bit, even for a single channel.
   function automatic int ch_w(input int num_ch);
      if (num_ch <= 2) begin
         return 1;
      end
      return $clog2(num_ch);
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: counter, active half-period, shadow half-period,
// pending flag, divided clock and rising-edge tick strobe.
//
// Divisor changes are staged in shadow_q and only moved into half_q at the
// terminal count where out_clk falls (end of a full period), or on the
// next cycle if the channel is disabled.  The divided clock therefore never
// sees a short high or low phase.
module clock_div_channel
   import clock_div_pkg::*;
#(
   parameter int               CNT_W    = DEF_CNT_W,
   parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_DEFAULT)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             cfg_we_i,
   input  logic [CNT_W-1:0] cfg_half_i,
   output logic             out_clk_o,
   output logic             tick_o,
   output logic             pending_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic             terminal;

   // cnt never exceeds half-1, so a plain equality compare is enough.
   assign terminal = (cnt_q == (half_q - CNT_W'(1)));

   // Next-state: config capture, counting, toggling and divisor apply.
   always_comb begin
      cnt_d    = cnt_q;
      half_d   = half_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      tick_d   = 1'b0;
      pend_d   = pend_q;

      // A write is only accepted while nothing is pending, so it never
      // collides with the apply paths below (they all require pend_q).
      if (cfg_we_i) begin
         shadow_d = cfg_half_i;
         pend_d   = 1'b1;
      end

      if (en_i) begin
         if (terminal) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = ~out_q;
            // Falling edge closes a full period: safe point to switch divisor.
            if (out_q && pend_q) begin
               half_d = shadow_q;
               pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (pend_q) begin
         // Disabled channel has no running period to protect: apply now
         // and restart from a clean low phase.
         half_d = shadow_q;
         cnt_d  = '0;
         out_d  = 1'b0;
         pend_d = 1'b0;
      end
   end

   // Channel state registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q    <= '0;
         half_q   <= DEF_HALF;
         shadow_q <= DEF_HALF;
         out_q    <= 1'b0;
         tick_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         tick_q   <= tick_d;
         pend_q   <= pend_d;
      end
   end

   assign out_clk_o = out_q;
   assign tick_o    = tick_q;
   assign pending_o = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider / tick generator.
// Top level: config decode, ready mux, error strobe and channel array.
//
// Config handshake (valid/ready): a request transfers on any cycle where
// cfgValid && cfgReady at posedge inClk.  cfgReady depends combinationally
// on cfgCh only (it is low while the addressed channel has a pending
// divisor).  While cfgValid is high and cfgReady low the requester keeps
// cfgCh/cfgHalf stable.  A transferred request with a zero half-period or
// an out-of-range channel is dropped and reported by a one-cycle cfgErr
// pulse on the following cycle.
module clock_divider_multi
   import clock_div_pkg::*;
#(
   parameter int          NUM_CH   = 4,
   parameter int          CNT_W    = DEF_CNT_W,
   parameter int unsigned DEF_HALF = DEF_HALF_DEFAULT,
   localparam int         CH_W     = ch_w(NUM_CH)
) (
   input  logic              inClk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] chEn,
   input  logic              cfgValid,
   output logic              cfgReady,
   input  logic [CH_W-1:0]   cfgCh,
   input  logic [CNT_W-1:0]  cfgHalf,
   output logic              cfgErr,
   output logic [NUM_CH-1:0] outClk,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] ch_we;
   logic              ch_ok;
   logic              half_ok;
   logic              cfg_fire;
   logic              cfg_err_q, cfg_err_d;

   // Channel decode and ready mux; unused channel codes are always ready
   // so a bad-channel request completes and can be flagged.
   always_comb begin
      ch_ok    = 1'b0;
      cfgReady = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cfgCh == CH_W'(c)) begin
            ch_ok    = 1'b1;
            cfgReady = ~pending[c];
         end
      end
   end

   assign half_ok   = |cfgHalf;
   assign cfg_fire  = cfgValid & cfgReady;
   assign cfg_err_d = cfg_fire & ~(ch_ok & half_ok);

   // Per-channel write strobes for accepted, well-formed requests.
   always_comb begin
      ch_we = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_we[c] = cfg_fire & half_ok & (cfgCh == CH_W'(c));
      end
   end

   // Registered one-cycle error strobe.
   always_ff @(posedge inClk) begin
      if (!reset) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfgErr = cfg_err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clock_div_channel #(
         .CNT_W    (CNT_W),
         .DEF_HALF (CNT_W'(DEF_HALF))
      ) u_ch (
         .clk_i      (inClk),
         .rst_n_i    (reset),
         .en_i       (chEn[g]),
         .cfg_we_i   (ch_we[g]),
         .cfg_half_i (cfgHalf),
         .out_clk_o  (outClk[g]),
         .tick_o     (tick[g]),
         .pending_o  (pending[g])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (NUM_CH=2, CNT_W=8, DEF_HALF=4),
// plus a NUM_CH=3 instance for the out-of-range channel case.
// Cycle k = state sampled 1ns after the k-th posedge following reset release.
module tb_clock_divider_multi;

   logic       inClk;
   logic       reset;
   logic [1:0] chEn;
   logic       cfgValid;
   logic       cfgReady;
   logic [0:0] cfgCh;
   logic [7:0] cfgHalf;
   logic       cfgErr;
   logic [1:0] outClk;
   logic [1:0] tick;

   logic [2:0] chEn3;
   logic       cfgValid3;
   logic       cfgReady3;
   logic [1:0] cfgCh3;
   logic [7:0] cfgHalf3;
   logic       cfgErr3;
   logic [2:0] outClk3;
   logic [2:0] tick3;

   int n_checks = 0;
   int n_errors = 0;

   clock_divider_multi #(.NUM_CH(2), .CNT_W(8), .DEF_HALF(4)) dut (
      .inClk    (inClk),
      .reset    (reset),
      .chEn     (chEn),
      .cfgValid (cfgValid),
      .cfgReady (cfgReady),
      .cfgCh    (cfgCh),
      .cfgHalf  (cfgHalf),
      .cfgErr   (cfgErr),
      .outClk   (outClk),
      .tick     (tick)
   );

   clock_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEF_HALF(4)) dut3 (
      .inClk    (inClk),
      .reset    (reset),
      .chEn     (chEn3),
      .cfgValid (cfgValid3),
      .cfgReady (cfgReady3),
      .cfgCh    (cfgCh3),
      .cfgHalf  (cfgHalf3),
      .cfgErr   (cfgErr3),
      .outClk   (outClk3),
      .tick     (tick3)
   );

   // Clock
   initial inClk = 1'b0;
   always #5 inClk = ~inClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge inClk);
      #1;
   endtask

   // Default half=4: high phase for cycles 4..7 of each 8-cycle period.
   function automatic bit ph(input int k);
      return ((k / 4) % 2) == 1;
   endfunction

   function automatic bit tk(input int k);
      return (k % 8) == 4;
   endfunction

   // Channel 1 after its switch to half=1 at the falling edge of cycle 24.
   function automatic bit ch1_out(input int k);
      return (k < 25) ? ph(k) : ((k % 2) == 1);
   endfunction

   function automatic bit ch1_tick(input int k);
      return (k < 25) ? tk(k) : ((k % 2) == 1);
   endfunction

   int exp_o0  [22] = '{1,1,1,1,0,0,1,1,0,0,0,1,1,1,0,0,0,1,1,1,0,0};
   int exp_rdy [22] = '{0,0,0,0,1,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1};

   initial begin
      reset     = 1'b0;
      chEn      = 2'b11;
      cfgValid  = 1'b0;
      cfgCh     = 1'b0;
      cfgHalf   = 8'd0;
      chEn3     = 3'b111;
      cfgValid3 = 1'b0;
      cfgCh3    = 2'd0;
      cfgHalf3  = 8'd0;

      // Reset state
      repeat (2) @(posedge inClk);
      #1;
      check("rst_out",   32'(outClk),   32'd0);
      check("rst_tick",  32'(tick),     32'd0);
      check("rst_err",   32'(cfgErr),   32'd0);
      check("rst_ready", 32'(cfgReady), 32'd1);
      check("rst_out3",  32'(outClk3),  32'd0);
      reset = 1'b1;

      // 1: free-running default divisor
      for (int k = 1; k <= 22; k++) begin
         step();
         check($sformatf("t1_out_k%0d", k),  32'(outClk),  32'({ph(k), ph(k)}));
         check($sformatf("t1_tick_k%0d", k), 32'(tick),    32'({tk(k), tk(k)}));
         check($sformatf("t1_out3_k%0d", k), 32'(outClk3), 32'({3{ph(k)}}));
      end

      // 2: ch1 -> half=1 during its high phase
      cfgCh    = 1'b1;
      cfgHalf  = 8'd1;
      cfgValid = 1'b1;
      check("t2_ready_pre", 32'(cfgReady), 32'd1);
      for (int k = 23; k <= 31; k++) begin
         step();
         if (k == 23) cfgValid = 1'b0;
         check($sformatf("t2_out0_k%0d", k),  32'(outClk[0]), 32'(ph(k)));
         check($sformatf("t2_tick0_k%0d", k), 32'(tick[0]),   32'(tk(k)));
         check($sformatf("t2_out1_k%0d", k),  32'(outClk[1]), 32'(ch1_out(k)));
         check($sformatf("t2_tick1_k%0d", k), 32'(tick[1]),   32'(ch1_tick(k)));
         check($sformatf("t2_ready_k%0d", k), 32'(cfgReady),  32'(k >= 24));
         check($sformatf("t2_err_k%0d", k),   32'(cfgErr),    32'd0);
      end

      // 3: rejected requests (zero half on main DUT, bad channel on dut3)
      cfgCh     = 1'b0;
      cfgHalf   = 8'd0;
      cfgValid  = 1'b1;
      cfgCh3    = 2'd3;
      cfgHalf3  = 8'd1;
      cfgValid3 = 1'b1;
      check("t3_ready_pre",  32'(cfgReady),  32'd1);
      check("t3_ready3_pre", 32'(cfgReady3), 32'd1);
      for (int k = 32; k <= 41; k++) begin
         step();
         if (k == 32) begin
            cfgValid  = 1'b0;
            cfgValid3 = 1'b0;
         end
         check($sformatf("t3_err_k%0d", k),   32'(cfgErr),     32'(k == 32));
         check($sformatf("t3_err3_k%0d", k),  32'(cfgErr3),    32'(k == 32));
         check($sformatf("t3_out0_k%0d", k),  32'(outClk[0]),  32'(ph(k)));
         check($sformatf("t3_out1_k%0d", k),  32'(outClk[1]),  32'(ch1_out(k)));
         check($sformatf("t3_out3_k%0d", k),  32'(outClk3),    32'({3{ph(k)}}));
         check($sformatf("t3_ready_k%0d", k), 32'(cfgReady),   32'd1);
      end

      // 4: ch0 disabled for posedges 42..46
      chEn[0] = 1'b0;
      for (int k = 42; k <= 56; k++) begin
         step();
         if (k <= 46) begin
            check($sformatf("t4_out0_k%0d", k),  32'(outClk[0]), 32'd0);
            check($sformatf("t4_tick0_k%0d", k), 32'(tick[0]),   32'd0);
         end else begin
            check($sformatf("t4_out0_k%0d", k),  32'(outClk[0]), 32'(ph(k - 5)));
            check($sformatf("t4_tick0_k%0d", k), 32'(tick[0]),   32'(tk(k - 5)));
         end
         check($sformatf("t4_out1_k%0d", k), 32'(outClk[1]), 32'(ch1_out(k)));
         if (k == 46) chEn[0] = 1'b1;
      end

      // 5: ch0 -> half=2, then half=3 queued behind it
      cfgCh    = 1'b0;
      cfgHalf  = 8'd2;
      cfgValid = 1'b1;
      check("t5_ready_pre", 32'(cfgReady), 32'd1);
      for (int i = 0; i < 22; i++) begin
         step();
         check($sformatf("t5_out0_k%0d", 57 + i),  32'(outClk[0]), 32'(exp_o0[i]));
         check($sformatf("t5_tick0_k%0d", 57 + i), 32'(tick[0]),
               32'(i == 0 || i == 6 || i == 11 || i == 17));
         check($sformatf("t5_out1_k%0d", 57 + i),  32'(outClk[1]), 32'(ch1_out(57 + i)));
         check($sformatf("t5_tick1_k%0d", 57 + i), 32'(tick[1]),   32'(ch1_tick(57 + i)));
         check($sformatf("t5_ready_k%0d", 57 + i), 32'(cfgReady),  32'(exp_rdy[i]));
         if (i == 0) cfgHalf = 8'd3;
         if (i == 5) cfgValid = 1'b0;
      end

      // 6: reset while ch1 has a pending divisor
      cfgCh    = 1'b1;
      cfgHalf  = 8'd5;
      cfgValid = 1'b1;
      check("t6_ready_pre", 32'(cfgReady), 32'd1);
      step();
      cfgValid = 1'b0;
      check("t6_ready_pend", 32'(cfgReady),  32'd0);
      check("t6_out1_pre",   32'(outClk[1]), 32'd1);
      reset = 1'b0;
      step();
      check("t6_rst_out",   32'(outClk),   32'd0);
      check("t6_rst_tick",  32'(tick),     32'd0);
      check("t6_rst_err",   32'(cfgErr),   32'd0);
      check("t6_rst_ready", 32'(cfgReady), 32'd1);
      reset = 1'b1;
      for (int j = 1; j <= 13; j++) begin
         step();
         check($sformatf("t6_out_j%0d", j),  32'(outClk),  32'({ph(j), ph(j)}));
         check($sformatf("t6_tick_j%0d", j), 32'(tick),    32'({tk(j), tk(j)}));
         check($sformatf("t6_out3_j%0d", j), 32'(outClk3), 32'({3{ph(j)}}));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
